// File: rtl/fetch_align_buffer.sv
// Halfword circular alignment queue between fetch and decode.
// Optional per-slot PC tracking is enabled with FETCH_ALIGN_PC_EN.
module fetch_align_buffer #(
  parameter int WIDTH = 4,
  parameter int ISSUE = 4,
  parameter int DEPTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic [32*WIDTH-1:0]        i_packet,
  input  logic [$clog2(2*WIDTH)-1:0] i_offset,
  input  logic                       i_valid,
`ifdef FETCH_ALIGN_PC_EN
  input  logic [31:0]                i_pc,
  output logic [32*ISSUE-1:0]        o_pc,
`endif
  output logic                       o_ready,
  output logic [32*ISSUE-1:0]        o_insts,
  output logic [ISSUE-1:0]           o_compressed,
  output logic [ISSUE-1:0]           o_valid,
  output logic [$clog2(ISSUE+1)-1:0] o_count,
  input  logic                       i_ready
);

  localparam int HW  = 2 * WIDTH;
  localparam int AW  = $clog2(DEPTH);
  localparam int OW  = $clog2(DEPTH + 1);
  localparam int OFW = $clog2(HW);
  localparam int CW  = $clog2(ISSUE + 1);
  localparam int PW  = OW + 1;

  logic [15:0]   r_mem [DEPTH];
`ifdef FETCH_ALIGN_PC_EN
  logic [31:0]   r_pcm [DEPTH];
`endif
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [OW-1:0] r_occ;

  logic [OW-1:0]    w_nin;
  logic [OW-1:0]    w_nout;
  logic [ISSUE-1:0] w_val;
  logic [ISSUE-1:0] w_cmp;
  logic [CW-1:0]    w_cnt;
  logic             w_wr;
  logic             w_rd;

  assign o_ready = r_occ <= OW'(DEPTH - HW);
  assign w_nin   = OW'(HW) - OW'(i_offset);
  assign w_wr    = i_valid && o_ready && !i_flush;
  assign w_rd    = i_ready && (w_cnt != '0) && !i_flush;

  // Walk the queue head: each slot begins where the previous one ended.
  always_comb begin
    logic [PW-1:0] pos;
    logic [PW-1:0] len;
    logic [AW-1:0] idx;
    logic [15:0]   lo;
    logic [15:0]   hi;
    logic          run;
    pos     = '0;
    run     = 1'b1;
    w_val   = '0;
    w_cmp   = '0;
    w_nout  = '0;
    w_cnt   = '0;
    o_insts = '0;
`ifdef FETCH_ALIGN_PC_EN
    o_pc    = '0;
`endif
    for (int k = 0; k < ISSUE; k++) begin
      idx = r_head + AW'(pos);
      lo  = r_mem[idx];
      hi  = r_mem[idx + AW'(1)];
      len = (lo[1:0] != 2'b11) ? PW'(1) : PW'(2);
      run = run && ((pos + len) <= {1'b0, r_occ});
      if (run) begin
        w_val[k] = 1'b1;
        w_cmp[k] = (len == PW'(1));
        o_insts[32*k +: 32] = w_cmp[k] ? {16'h0, lo} : {hi, lo};
`ifdef FETCH_ALIGN_PC_EN
        o_pc[32*k +: 32] = r_pcm[idx];
`endif
        w_nout = w_nout + OW'(len);
        w_cnt  = w_cnt + CW'(1);
      end
      pos = pos + len;
    end
  end

  assign o_valid      = w_val;
  assign o_compressed = w_cmp;
  assign o_count      = w_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else if (i_flush) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      if (w_wr) r_tail <= r_tail + AW'(w_nin);
      if (w_rd) r_head <= r_head + AW'(w_nout);
      r_occ <= r_occ + (w_wr ? w_nin : '0)
                     - (w_rd ? w_nout : '0);
    end
  end

  // Storage carries no reset; validity is governed by r_occ alone.
  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      for (int h = 0; h < HW; h++) begin
        if (OFW'(h) >= i_offset) begin
          r_mem[r_tail + AW'(h) - AW'(i_offset)] <=
            i_packet[16*h +: 16];
`ifdef FETCH_ALIGN_PC_EN
          r_pcm[r_tail + AW'(h) - AW'(i_offset)] <=
            i_pc + 32'(2 * h);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Bench for fetch_align_buffer: queue-based reference model plus
// directed scenarios with literal expectations.
module tb_fetch_align_buffer;

  logic         clk;
  logic         rst_n;
  logic         i_flush;
  logic [127:0] i_packet;
  logic [2:0]   i_offset;
  logic         i_valid;
  logic [31:0]  tb_pc;
  logic         o_ready;
  logic [127:0] o_insts;
  logic [3:0]   o_compressed;
  logic [3:0]   o_valid;
  logic [2:0]   o_count;
  logic         i_ready;
`ifdef FETCH_ALIGN_PC_EN
  logic [127:0] o_pc;
`endif

  int checks;
  int failures;

  logic [15:0] q[$];
  logic [31:0] qpc[$];

  fetch_align_buffer #(.WIDTH(4), .ISSUE(4), .DEPTH(16)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_flush(i_flush),
    .i_packet(i_packet),
    .i_offset(i_offset),
    .i_valid(i_valid),
`ifdef FETCH_ALIGN_PC_EN
    .i_pc(tb_pc),
    .o_pc(o_pc),
`endif
    .o_ready(o_ready),
    .o_insts(o_insts),
    .o_compressed(o_compressed),
    .o_valid(o_valid),
    .o_count(o_count),
    .i_ready(i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected slot view: carve the model queue front into instructions.
  function automatic void walk(output logic [3:0] v,
                               output logic [3:0] c,
                               output logic [127:0] ins,
                               output logic [127:0] pcs,
                               output int nout);
    int p;
    int len;
    bit ok;
    p = 0; ok = 1; v = 0; c = 0; ins = 0; pcs = 0; nout = 0;
    for (int k = 0; k < 4; k++) begin
      if (ok && p < q.size()) begin
        len = (q[p][1:0] != 2'b11) ? 1 : 2;
        if (p + len <= q.size()) begin
          v[k] = 1'b1;
          c[k] = (len == 1);
          ins[32*k +: 32] = (len == 1) ? {16'h0, q[p]}
                                       : {q[p+1], q[p]};
          pcs[32*k +: 32] = qpc[p];
          nout += len;
          p += len;
        end else ok = 0;
      end else ok = 0;
    end
  endfunction

  function automatic int model_nout();
    logic [3:0] v, c;
    logic [127:0] ins, pcs;
    int n;
    walk(v, c, ins, pcs, n);
    return n;
  endfunction

  function automatic bit model_ready();
    return (16 - q.size()) >= 8;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      qpc.delete();
    end else if (i_flush) begin
      q.delete();
      qpc.delete();
    end else if (i_valid && model_ready()) begin
      if (i_ready) repeat (model_nout()) begin
        void'(q.pop_front());
        void'(qpc.pop_front());
      end
      for (int h = 0; h < 8; h++)
        if (h >= i_offset) begin
          q.push_back(i_packet[16*h +: 16]);
          qpc.push_back(tb_pc + 32'(2 * h));
        end
    end else if (i_ready) begin
      repeat (model_nout()) begin
        void'(q.pop_front());
        void'(qpc.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] ev, ec;
    logic [127:0] ei, ep;
    int n;
    if (rst_n) begin
      walk(ev, ec, ei, ep, n);
      chk("m_valid", o_valid, ev);
      chk("m_comp", o_compressed, ec);
      chk("m_insts", o_insts, ei);
      chk("m_count", o_count, $countones(ev));
      chk("m_ready", o_ready, model_ready());
`ifdef FETCH_ALIGN_PC_EN
      chk("m_pc", o_pc, ep);
`endif
    end
  end

  function automatic logic [127:0] pk_c(input logic [15:0] b);
    logic [127:0] r;
    for (int h = 0; h < 8; h++) r[16*h +: 16] = b + 16'(h * 4);
    return r;
  endfunction

  function automatic logic [127:0] pk_w(input logic [15:0] hb,
                                        input logic [15:0] lb);
    logic [127:0] r;
    for (int i = 0; i < 4; i++)
      r[32*i +: 32] = {hb + 16'(i), lb + 16'(i * 16)};
    return r;
  endfunction

  task automatic step(input logic f, input logic v,
                      input logic [127:0] p, input logic [2:0] off,
                      input logic r);
    i_flush  = f;
    i_valid  = v;
    i_packet = p;
    i_offset = off;
    i_ready  = r;
    @(posedge clk);
    #1;
    tb_pc = tb_pc + 32'h40;
  endtask

  task automatic drain();
    i_flush = 0;
    i_valid = 0;
    i_ready = 1;
    for (int i = 0; i < 12 && o_count != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", o_valid, 4'h0);
  endtask

  logic [127:0] pa, pb;

  initial begin
    checks = 0; failures = 0;
    rst_n = 0; i_flush = 0; i_valid = 0; i_ready = 0;
    i_packet = '0; i_offset = '0; tb_pc = 32'h8000_0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_valid", o_valid, 4'h0);
    chk("rst_count", o_count, 3'd0);

    // four 32-bit instructions
    step(0, 1, pk_w(16'hA000, 16'h1003), 0, 0);
    chk("t1_valid", o_valid, 4'hF);
    chk("t1_count", o_count, 3'd4);
    chk("t1_comp", o_compressed, 4'h0);
    chk("t1_slot0", o_insts[31:0], 32'hA0001003);
    drain();

    // eight compressed, consumed in two groups
    step(0, 1, pk_c(16'h4000), 0, 1);
    chk("t2_count_a", o_count, 3'd4);
    chk("t2_slot3_a", o_insts[127:96], 32'h0000400C);
    step(0, 0, '0, 0, 1);
    chk("t2_slot0_b", o_insts[31:0], 32'h00004010);
    step(0, 0, '0, 0, 1);
    chk("t2_empty", o_valid, 4'h0);

    // straddle across packets
    pa = pk_c(16'h5000);
    pa[127:112] = 16'h7773;
    pb = pk_c(16'h6000);
    pb[15:0] = 16'hBEEF;
    step(0, 1, pa, 0, 0);
    step(0, 0, '0, 0, 1);
    chk("t3_partial", o_valid, 4'b0111);
    step(0, 0, '0, 0, 1);
    chk("t3_frag_held", o_valid, 4'h0);
    step(0, 1, pb, 0, 0);
    chk("t3_joined", o_insts[31:0], 32'hBEEF7773);
    chk("t3_comp0", o_compressed[0], 1'b0);
    drain();

    // start offset 3
    step(0, 1, pk_c(16'h3000), 3, 0);
    chk("t4_count_a", o_count, 3'd4);
    chk("t4_slot0", o_insts[31:0], 32'h0000300C);
    step(0, 0, '0, 0, 1);
    chk("t4_count_b", o_count, 3'd1);
    chk("t4_last", o_insts[31:0], 32'h0000301C);
    step(0, 0, '0, 0, 1);

    // move head to 11, then fill with i_ready low
    step(0, 1, pk_c(16'h2000), 2, 0);
    drain();
    step(0, 1, pk_w(16'hC000, 16'h1003), 0, 0);
    chk("t5_wrap_slot", o_insts[95:64], 32'hC0021023);
    step(0, 1, pk_w(16'hD000, 16'h1103), 0, 0);
    chk("t5_full", o_ready, 1'b0);
    step(0, 1, pk_w(16'hE000, 16'h1203), 0, 0);
    step(0, 1, pk_w(16'hE000, 16'h1203), 0, 0);
    drain();

    // flush with a packet offered
    step(0, 1, pk_c(16'h1000), 2, 0);
    chk("t6_held", o_count, 3'd4);
    step(1, 1, pk_c(16'h7000), 0, 0);
    chk("t6_valid", o_valid, 4'h0);
    chk("t6_ready", o_ready, 1'b1);
    chk("t6_count", o_count, 3'd0);
    step(0, 0, '0, 0, 0);
    chk("t6_dropped", o_valid, 4'h0);

    // asynchronous reset mid-operation
    step(0, 1, pk_c(16'h0800), 0, 0);
    chk("t7_pre", o_count, 3'd4);
    i_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("t7_async_valid", o_valid, 4'h0);
    chk("t7_async_ready", o_ready, 1'b1);
    @(negedge clk);
    rst_n = 1;
    step(0, 0, '0, 0, 0);
    chk("t7_after", o_count, 3'd0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
